// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Requester handshake and RAM pin bundle for mem_port_arbiter.
//                The slave view belongs to the arbiter. The master view
//                belongs to the requesters and the RAM side.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) ();
  logic              req_valid_0;
  logic              req_valid_1;
  logic              req_ready_0;
  logic              req_ready_1;
  logic              req_we_0;
  logic              req_we_1;
  logic [ADDR_W-1:0] req_addr_0;
  logic [ADDR_W-1:0] req_addr_1;
  logic [DATA_W-1:0] req_wdata_0;
  logic [DATA_W-1:0] req_wdata_1;
  logic              rsp_valid_0;
  logic              rsp_valid_1;
  logic [DATA_W-1:0] rsp_rdata_0;
  logic [DATA_W-1:0] rsp_rdata_1;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid_0, req_valid_1, req_we_0, req_we_1,
    input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
    output mem_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid_0, req_valid_1, req_we_0, req_we_1,
    output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
    input  mem_en, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-requester arbiter and sequencer for a single-port
//                synchronous RAM. The RAM writes when en=1. When en=0 it
//                registers the read address, and read data is combinational
//                from that registered address. The arbiter accepts one
//                request at a time and returns read data or a write
//                acknowledge to the requester that issued it.
//                Build option ARB_FIXED_PRIO_EN: requester 0 always wins a
//                tie, and no round-robin pointer is kept. By default, ties
//                alternate by round-robin.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_we;
  logic              r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid_0;
  logic              r_rsp_valid_1;
  logic [DATA_W-1:0] r_rsp_rdata_0;
  logic [DATA_W-1:0] r_rsp_rdata_1;

  logic              w_win;
  logic              w_accept;
  logic              w_rdy_0;
  logic              w_rdy_1;
  logic              w_mem_en;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_rsp_set;
  logic [DATA_W-1:0] w_rsp_data;

`ifdef ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid.
  assign w_win = ~bus.req_valid_0;
`else
  // Id of the last winner. Its reset value of 1 lets requester 0 win the first tie.
  logic r_rr;

  // A tie goes to the requester that did not win last time. Otherwise the only valid requester wins.
  assign w_win = (bus.req_valid_0 && bus.req_valid_1) ? ~r_rr : ~bus.req_valid_0;

  // Record the winner on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rr <= 1'b1;
    else if (w_accept) r_rr <= w_win;
  end
`endif

  // State register. Reset returns to IDLE at once, so mem_en drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state, grant, RAM pins and response-capture strobe.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_rdy_0     = 1'b0;
    w_rdy_1     = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_rsp_set   = 1'b0;
    w_rsp_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_0 || bus.req_valid_1) begin
          w_accept = 1'b1;
          w_rdy_0  = ~w_win;
          w_rdy_1  = w_win;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        if (r_we) begin
          // A write ack carries zero data and is ready now.
          w_mem_en  = 1'b1;
          w_rsp_set = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_next    = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        // The RAM registered the address at the EXEC edge, so its output is valid now.
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        w_rsp_set   = 1'b1;
        w_rsp_data  = bus.mem_rdata;
        w_next      = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Latch the winning request's fields and its id at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_id    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= w_win ? bus.req_we_1    : bus.req_we_0;
      r_id    <= w_win;
      r_addr  <= w_win ? bus.req_addr_1  : bus.req_addr_0;
      r_wdata <= w_win ? bus.req_wdata_1 : bus.req_wdata_0;
    end
  end

  // Registered response. It is a one-cycle pulse to the originating requester and is zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid_0 <= 1'b0;
      r_rsp_valid_1 <= 1'b0;
      r_rsp_rdata_0 <= '0;
      r_rsp_rdata_1 <= '0;
    end else begin
      r_rsp_valid_0 <= w_rsp_set & ~r_id;
      r_rsp_valid_1 <= w_rsp_set &  r_id;
      r_rsp_rdata_0 <= (w_rsp_set & ~r_id) ? w_rsp_data : '0;
      r_rsp_rdata_1 <= (w_rsp_set &  r_id) ? w_rsp_data : '0;
    end
  end

  assign bus.req_ready_0 = w_rdy_0;
  assign bus.req_ready_1 = w_rdy_1;
  assign bus.rsp_valid_0 = r_rsp_valid_0;
  assign bus.rsp_valid_1 = r_rsp_valid_1;
  assign bus.rsp_rdata_0 = r_rsp_rdata_0;
  assign bus.rsp_rdata_1 = r_rsp_rdata_1;
  assign bus.mem_en      = w_mem_en;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. It models the
//                single-port RAM and predicts grants, latency and response
//                data from a shadow memory and per-transaction cycle counts.
//                Define ARB_FIXED_PRIO_EN to match the fixed-priority build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write when en=1, otherwise register the read address.
  logic [DATA_W-1:0] ram [16];
  logic [ADDR_W-1:0] ram_ra  = '0;
  bit                ram_clr = 1'b1;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      ram_clr <= 1'b0;
    end else if (bus.mem_en) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end else begin
      ram_ra <= bus.mem_addr;
    end
  end
  assign bus.mem_rdata = ram[ram_ra];

  int                vectors = 0;
  int                errors  = 0;
  logic [DATA_W-1:0] shadow [16];
  bit                m_last;

  // Flag order: busy, mem_en, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1.
  function automatic logic [5:0] flags();
    return {busy, bus.mem_en, bus.rsp_valid_0, bus.rsp_valid_1, bus.req_ready_0, bus.req_ready_1};
  endfunction

  task automatic idle_inputs();
    bus.req_valid_0 = 1'b0; bus.req_we_0 = 1'b0; bus.req_addr_0 = '0; bus.req_wdata_0 = '0;
    bus.req_valid_1 = 1'b0; bus.req_we_1 = 1'b0; bus.req_addr_1 = '0; bus.req_wdata_1 = '0;
  endtask

  task automatic drive(input int id, input bit we, input logic [3:0] a, input logic [31:0] d);
    if (id == 0) begin
      bus.req_valid_0 = 1'b1; bus.req_we_0 = we; bus.req_addr_0 = a; bus.req_wdata_0 = d;
    end else begin
      bus.req_valid_1 = 1'b1; bus.req_we_1 = we; bus.req_addr_1 = a; bus.req_wdata_1 = d;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (flags() !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want %b", flags(), 6'b0);
    end
    vectors++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rsp_rdata_0, bus.rsp_rdata_1} !== '0) begin
      errors++; $display("FAIL reset_buses: got addr %h wdata %h rd0 %h rd1 %h want all 0",
                         bus.mem_addr, bus.mem_wdata, bus.rsp_rdata_0, bus.rsp_rdata_1);
    end
    rst_n = 1'b1;
    m_last = 1'b1;
    @(negedge clk);
    vectors++;
    if (flags() !== 6'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b want %b", flags(), 6'b0);
    end
  endtask

  // One isolated transaction, checked cycle by cycle against the fixed latencies.
  task automatic test_txn(input string name, input int id, input bit we,
                          input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic [5:0]  exp_f;
    logic [3:0]  exp_a;
    int          last;
    exp_rd = we ? 32'h0 : shadow[addr];
    last   = we ? 2 : 3;
    @(posedge clk); #1;
    drive(id, we, addr, data);
    @(negedge clk);
    exp_f = {4'b0000, id == 0, id == 1};
    vectors++;
    if (flags() !== exp_f) begin
      errors++; $display("FAIL %s_accept: got %b want %b", name, flags(), exp_f);
    end
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) idle_inputs();
      @(negedge clk);
      exp_f = {k <= last, we && k == 1, id == 0 && k == last, id == 1 && k == last, 2'b00};
      exp_a = (k == 1 || (!we && k == 2)) ? addr : 4'h0;
      vectors++;
      if (flags() !== exp_f || bus.mem_addr !== exp_a) begin
        errors++; $display("FAIL %s_cycle%0d: got flags %b addr %h want flags %b addr %h",
                           name, k, flags(), bus.mem_addr, exp_f, exp_a);
      end
      if (k == last) begin
        got_rd = (id == 1) ? bus.rsp_rdata_1 : bus.rsp_rdata_0;
        vectors++;
        if (got_rd !== exp_rd) begin
          errors++; $display("FAIL %s_rdata: got %h want %h", name, got_rd, exp_rd);
        end
      end
      if (we && k == 1) begin
        vectors++;
        if (bus.mem_wdata !== data) begin
          errors++; $display("FAIL %s_wdata: got %h want %h", name, bus.mem_wdata, data);
        end
      end
    end
    if (we) shadow[addr] = data;
    m_last = (id == 1);
  endtask

  // Reset asserted during EXEC of a write. The write must not happen and no response may follow.
  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    drive(0, 1'b1, 4'h5, 32'h12345678);
    @(negedge clk);
    vectors++;
    if (bus.req_ready_0 !== 1'b1) begin
      errors++; $display("FAIL rmw_accept: got ready0 %b want 1", bus.req_ready_0);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b1) begin
      errors++; $display("FAIL rmw_exec_en: got %b want 1", bus.mem_en);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (flags() !== 6'b0) begin
      errors++; $display("FAIL rmw_async_drop: got %b want %b", flags(), 6'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (flags() !== 6'b0) begin
        errors++; $display("FAIL rmw_no_rsp: got %b want %b", flags(), 6'b0);
      end
    end
  endtask

  // Traffic from both requesters, compared every cycle against a latency and
  // shadow-memory model. mode 1: both requesters read continuously (req0
  // reads addr 1 with a finite quota, req1 reads addr 2). mode 0: random.
  task automatic test_traffic(input int mode, input int gen_cycles);
    bit          pv  [2];
    bit          pwe [2];
    logic [3:0]  pa  [2];
    logic [31:0] pd  [2];
    int          quota0;
    int          left;
    int          aid;
    int          win;
    bit          aw;
    bit          acc;
    bit          done;
    logic [31:0] ard;
    logic [31:0] got_rd;
    logic [5:0]  exp_f;
    quota0 = (mode == 1) ? 6 : 32'h7fffffff;
    left = 0; aid = 0; aw = 1'b0; done = 1'b0; ard = '0;
    for (int r = 0; r < 2; r++) begin pv[r] = 1'b0; pwe[r] = 1'b0; pa[r] = '0; pd[r] = '0; end
    for (int cyc = 0; cyc < gen_cycles + 40 && !done; cyc++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && cyc < gen_cycles) begin
          if (mode == 1) begin
            if (r == 1 || quota0 > 0) begin
              pv[r] = 1'b1; pwe[r] = 1'b0; pa[r] = (r == 1) ? 4'h2 : 4'h1; pd[r] = '0;
              if (r == 0) quota0--;
            end
          end else if ($urandom_range(0, 2) != 0) begin
            pv[r] = 1'b1; pwe[r] = 1'($urandom_range(0, 1));
            pa[r] = 4'($urandom_range(0, 15)); pd[r] = $urandom;
          end
        end
      end
      idle_inputs();
      if (pv[0]) drive(0, pwe[0], pa[0], pd[0]);
      if (pv[1]) drive(1, pwe[1], pa[1], pd[1]);
      @(negedge clk);
      if (pv[0] && pv[1]) win = FIXED ? 0 : (m_last ? 0 : 1);
      else                win = pv[0] ? 0 : 1;
      acc   = (left == 0) && (pv[0] || pv[1]);
      exp_f = {left > 0, aw && left == 2, left == 1 && aid == 0, left == 1 && aid == 1,
               acc && win == 0, acc && win == 1};
      vectors++;
      if (flags() !== exp_f) begin
        errors++; $display("FAIL traffic_m%0d_c%0d: got %b want %b", mode, cyc, flags(), exp_f);
      end
      if (left == 1) begin
        got_rd = (aid == 1) ? bus.rsp_rdata_1 : bus.rsp_rdata_0;
        vectors++;
        if (got_rd !== ard) begin
          errors++; $display("FAIL traffic_rdata_m%0d_c%0d: got %h want %h", mode, cyc, got_rd, ard);
        end
      end
      if (left > 0) begin
        left--;
      end else if (acc) begin
        aw  = pwe[win];
        aid = win;
        ard = aw ? 32'h0 : shadow[pa[win]];
        if (aw) shadow[pa[win]] = pd[win];
        left    = aw ? 2 : 3;
        m_last  = (win == 1);
        pv[win] = 1'b0;
      end
      if (cyc >= gen_cycles && !pv[0] && !pv[1] && left == 0) done = 1'b1;
    end
    idle_inputs();
    vectors++;
    if (!done) begin
      errors++; $display("FAIL traffic_drain_m%0d: got pending work want drained", mode);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    idle_inputs();
    test_reset();
    test_txn("wr3",  0, 1'b1, 4'h3, 32'hDEADBEEF);
    test_txn("raw3", 1, 1'b0, 4'h3, 32'h0);
    test_txn("wr0",  0, 1'b1, 4'h0, 32'hFFFFFFFF);
    test_txn("wr15", 1, 1'b1, 4'hF, 32'hFFFFFFFF);
    test_txn("rd15", 0, 1'b0, 4'hF, 32'h0);
    test_txn("wr15z", 0, 1'b1, 4'hF, 32'h0);
    test_txn("rd0",  1, 1'b0, 4'h0, 32'h0);
    test_txn("rd15z", 1, 1'b0, 4'hF, 32'h0);
    test_txn("wr1",  0, 1'b1, 4'h1, 32'h11111111);
    test_txn("wr2",  1, 1'b1, 4'h2, 32'h22222222);
    test_txn("wr5",  0, 1'b1, 4'h5, 32'hA5A50005);
    test_reset_mid_write();
    test_txn("rd5",  1, 1'b0, 4'h5, 32'h0);
    test_traffic(1, 60);
    test_traffic(0, 800);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
